i2c_reg_sequencer: RTL

//  Wishbone master that drives the I2C master core's register file to run complete
//  8-bit register transactions on an I2C slave:
//   - write: S dev+W reg data P
//   - read:  S dev+W reg Sr dev+R data(NACK) P

---
 rtl/i2c_reg_sequencer_pkg.sv | 49 ++++
 rtl/i2c_seq_wb_port.sv | 62 ++++++
 rtl/i2c_reg_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared definitions for the I2C register sequencer: register addresses of the
// I2C master core, command-register bit values, status-register bit indices,
// result codes and the sequencer state encoding.
package i2c_reg_sequencer_pkg;

   // Core register map
   localparam logic [2:0] ADR_PRER_LO = 3'd0;
   localparam logic [2:0] ADR_PRER_HI = 3'd1;
   localparam logic [2:0] ADR_CTR     = 3'd2;
   localparam logic [2:0] ADR_TXR_RXR = 3'd3;
   localparam logic [2:0] ADR_CR_SR   = 3'd4;

   // Command register bits (bit0 = IACK is never set)
   localparam logic [7:0] CR_STA = 8'h80;
   localparam logic [7:0] CR_STO = 8'h40;
   localparam logic [7:0] CR_RD  = 8'h20;
   localparam logic [7:0] CR_WR  = 8'h10;
   localparam logic [7:0] CR_ACK = 8'h08;

   // Control register: core enable, interrupt disabled
   localparam logic [7:0] CTR_EN = 8'h80;

   // Status register bit indices
   localparam int SR_RXACK = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_TIP   = 1;

   // Result codes reported on err_o
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NACK    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      ST_INIT_PRL = 4'd0,
      ST_INIT_PRH = 4'd1,
      ST_INIT_CTR = 4'd2,
      ST_IDLE     = 4'd3,
      ST_TXR      = 4'd4,
      ST_CR       = 4'd5,
      ST_GAP      = 4'd6,
      ST_POLL     = 4'd7,
      ST_CHK      = 4'd8,
      ST_RXR      = 4'd9,
      ST_NSTO     = 4'd10,
      ST_BUSY     = 4'd11,
      ST_TSTO     = 4'd12
   } seq_state_e;

endpackage

// File: rtl/i2c_seq_wb_port.sv
// Single-access Wishbone master.
// A request pulse while idle starts one access; cyc/stb and the latched
// adr/dat/we are held until m_ack_i. The access ends on the ack edge, and
// done pulses in the following cycle with rdata holding the sampled read data.
// Because done is registered, cyc/stb are always low for at least one cycle
// before the next access can start.
// Ports:
//   wb_clk_i, arst_i        clock, async active-low reset
//   req, we, adr, wdata     access request from the sequencer
//   busy, done, rdata       access in flight / finished pulse / read data
//   m_*                     Wishbone master bus
module i2c_seq_wb_port (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       req,
   input  logic       we,
   input  logic [2:0] adr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic [2:0] m_adr_o,
   output logic [7:0] m_dat_o,
   input  logic [7:0] m_dat_i,
   output logic       m_we_o,
   output logic       m_stb_o,
   output logic       m_cyc_o,
   input  logic       m_ack_i
);

   logic cyc;

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         cyc     <= 1'b0;
         done    <= 1'b0;
         rdata   <= 8'h00;
         m_adr_o <= 3'd0;
         m_dat_o <= 8'h00;
         m_we_o  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cyc) begin
            if (m_ack_i) begin
               cyc  <= 1'b0;
               done <= 1'b1;
               if (!m_we_o) rdata <= m_dat_i;
            end
         end else if (req) begin
            cyc     <= 1'b1;
            m_we_o  <= we;
            m_adr_o <= adr;
            m_dat_o <= wdata;
         end
      end
   end

   assign busy    = cyc;
   assign m_cyc_o = cyc;
   assign m_stb_o = cyc;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Wishbone master that programs the I2C master core and runs complete 8-bit
// register transactions (write: S dev+W reg data P, read: S dev+W reg Sr
// dev+R data NACK P). After reset it writes PRER lo/hi and CTR once, then
// accepts host requests, reporting completion on done_o/err_o/rdata_o.
// Handshake: a request is taken on a clock edge where cmd_valid_i and
// cmd_ready_o are both high; the host holds cmd_* stable until then.
// Ports:
//   wb_clk_i, arst_i              clock, async active-low reset
//   cmd_*                         host request (valid/ready, rw, dev, reg, wdata)
//   done_o, err_o, rdata_o        completion pulse, result code, read data
//   m_*                           Wishbone master to the I2C core
module i2c_reg_sequencer
   import i2c_reg_sequencer_pkg::*;
#(
   parameter logic [15:0] PRESCALE  = 16'd199,
   parameter int          TIMEOUT_W = 16
) (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_rw_i,
   input  logic [6:0] cmd_dev_i,
   input  logic [7:0] cmd_reg_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       done_o,
   output logic [1:0] err_o,
   output logic [7:0] rdata_o,
   output logic [2:0] m_adr_o,
   output logic [7:0] m_dat_o,
   input  logic [7:0] m_dat_i,
   output logic       m_we_o,
   output logic       m_stb_o,
   output logic       m_cyc_o,
   input  logic       m_ack_i
);

   localparam logic [TIMEOUT_W-1:0] TO_LIMIT = '1;

   seq_state_e           state, state_nxt;
   logic [2:0]           step;
   logic                 cmd_rw;
   logic [6:0]           cmd_dev;
   logic [7:0]           cmd_reg, cmd_wdata;
   logic [TIMEOUT_W-1:0] to_cnt;
   logic                 to_hit;

   logic                 wb_acc, wb_req, wb_we, wb_busy, wb_done;
   logic [2:0]           wb_adr;
   logic [7:0]           wb_wdata, wb_rdata;
   logic [7:0]           txr_byte, cr_byte;

   logic                 fin, fin_rd, step_inc;
   logic [1:0]           fin_err;

   assign to_hit      = (to_cnt == TO_LIMIT);
   assign cmd_ready_o = (state == ST_IDLE);

   // Per-step bytes. Step 3 of a read has no TXR byte (receive with NACK+STOP).
   always_comb begin
      txr_byte = 8'h00;
      cr_byte  = 8'h00;
      case (step)
         3'd0: begin txr_byte = {cmd_dev, 1'b0}; cr_byte = CR_STA | CR_WR; end
         3'd1: begin txr_byte = cmd_reg;         cr_byte = CR_WR;          end
         3'd2: begin
            if (cmd_rw) begin txr_byte = {cmd_dev, 1'b1}; cr_byte = CR_STA | CR_WR; end
            else        begin txr_byte = cmd_wdata;       cr_byte = CR_WR | CR_STO; end
         end
         3'd3: cr_byte = CR_RD | CR_ACK | CR_STO;
         default: ;
      endcase
   end

   // State register and datapath
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state     <= ST_INIT_PRL;
         step      <= 3'd0;
         cmd_rw    <= 1'b0;
         cmd_dev   <= 7'd0;
         cmd_reg   <= 8'h00;
         cmd_wdata <= 8'h00;
         to_cnt    <= '0;
         done_o    <= 1'b0;
         err_o     <= ERR_OK;
         rdata_o   <= 8'h00;
      end else begin
         state  <= state_nxt;
         done_o <= fin;
         if (fin) begin
            err_o <= fin_err;
            if (fin_rd) rdata_o <= wb_rdata;
         end
         if (state == ST_IDLE && cmd_valid_i) begin
            cmd_rw    <= cmd_rw_i;
            cmd_dev   <= cmd_dev_i;
            cmd_reg   <= cmd_reg_i;
            cmd_wdata <= cmd_wdata_i;
            step      <= 3'd0;
         end else if (step_inc) begin
            step <= step + 3'd1;
         end
         // Counter is zero whenever a poll state is entered; saturates at the limit.
         if (state == ST_POLL || state == ST_BUSY) begin
            if (!to_hit) to_cnt <= to_cnt + TIMEOUT_W'(1);
         end else begin
            to_cnt <= '0;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      fin       = 1'b0;
      fin_err   = ERR_OK;
      fin_rd    = 1'b0;
      step_inc  = 1'b0;
      unique case (state)
         ST_INIT_PRL: if (wb_done) state_nxt = ST_INIT_PRH;
         ST_INIT_PRH: if (wb_done) state_nxt = ST_INIT_CTR;
         ST_INIT_CTR: if (wb_done) state_nxt = ST_IDLE;
         ST_IDLE:     if (cmd_valid_i) state_nxt = ST_TXR;
         ST_TXR:      if (wb_done) state_nxt = ST_CR;
         ST_CR:       if (wb_done) state_nxt = ST_GAP;
         // TIP only rises the cycle after the CR write lands in the core.
         ST_GAP:      state_nxt = ST_POLL;
         ST_POLL: begin
            if (wb_done && !wb_rdata[SR_TIP])
               state_nxt = (cmd_rw && step == 3'd3) ? ST_RXR : ST_CHK;
            else if (to_hit && !wb_busy)
               state_nxt = ST_TSTO;
         end
         ST_CHK: begin
            // wb_rdata still holds the last SR read
            if (wb_rdata[SR_RXACK]) begin
               state_nxt = ST_NSTO;
            end else if (!cmd_rw && step == 3'd2) begin
               state_nxt = ST_IDLE;
               fin       = 1'b1;
            end else begin
               step_inc  = 1'b1;
               state_nxt = (cmd_rw && step == 3'd2) ? ST_CR : ST_TXR;
            end
         end
         ST_RXR: if (wb_done) begin
            state_nxt = ST_IDLE;
            fin       = 1'b1;
            fin_rd    = 1'b1;
         end
         ST_NSTO: if (wb_done) state_nxt = ST_BUSY;
         ST_BUSY: begin
            if ((wb_done && !wb_rdata[SR_BUSY]) || (to_hit && !wb_busy)) begin
               state_nxt = ST_IDLE;
               fin       = 1'b1;
               fin_err   = ERR_NACK;
            end
         end
         ST_TSTO: if (wb_done) begin
            state_nxt = ST_IDLE;
            fin       = 1'b1;
            fin_err   = ERR_TIMEOUT;
         end
         default: state_nxt = ST_INIT_PRL;
      endcase
   end

   // Bus access selection; a new access is requested only when the port is
   // idle and not in its completion cycle.
   always_comb begin
      wb_acc   = 1'b1;
      wb_we    = 1'b1;
      wb_adr   = ADR_CR_SR;
      wb_wdata = 8'h00;
      case (state)
         ST_INIT_PRL: begin wb_adr = ADR_PRER_LO; wb_wdata = PRESCALE[7:0];  end
         ST_INIT_PRH: begin wb_adr = ADR_PRER_HI; wb_wdata = PRESCALE[15:8]; end
         ST_INIT_CTR: begin wb_adr = ADR_CTR;     wb_wdata = CTR_EN;         end
         ST_TXR:      begin wb_adr = ADR_TXR_RXR; wb_wdata = txr_byte;       end
         ST_CR:       wb_wdata = cr_byte;
         ST_POLL, ST_BUSY: begin wb_we = 1'b0; wb_acc = !to_hit; end
         ST_RXR:      begin wb_we = 1'b0; wb_adr = ADR_TXR_RXR; end
         ST_NSTO, ST_TSTO: wb_wdata = CR_STO;
         default:     wb_acc = 1'b0;
      endcase
      wb_req = wb_acc && !wb_busy && !wb_done;
   end

   i2c_seq_wb_port u_wb (
      .wb_clk_i (wb_clk_i),
      .arst_i   (arst_i),
      .req      (wb_req),
      .we       (wb_we),
      .adr      (wb_adr),
      .wdata    (wb_wdata),
      .busy     (wb_busy),
      .done     (wb_done),
      .rdata    (wb_rdata),
      .m_adr_o  (m_adr_o),
      .m_dat_o  (m_dat_o),
      .m_dat_i  (m_dat_i),
      .m_we_o   (m_we_o),
      .m_stb_o  (m_stb_o),
      .m_cyc_o  (m_cyc_o),
      .m_ack_i  (m_ack_i)
   );

endmodule
